// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word types plus instruction-cache frame and state types
package cpu_types_pkg;
  localparam int WORD_W   = 32;
  localparam int BYTE_OFF = 2;

  typedef logic [WORD_W-1:0] word_t;

  localparam int ICACHE_NSETS = 16;
  localparam int ITAG_W       = WORD_W - BYTE_OFF - $clog2(ICACHE_NSETS);

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with single-word fills
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  input  logic              flush,
  output logic [WORD_W-1:0] hit_count,
  output logic [WORD_W-1:0] miss_count
);
  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = WORD_W - BYTE_OFF - IDX_W;

  logic [NSETS-1:0]           valid_q, valid_d;
  logic [TAG_W-1:0]           tag_mem  [NSETS];
  word_t                      data_mem [NSETS];
  icache_state_t              state_q, state_d;
  logic [WORD_W-BYTE_OFF-1:0] miss_addr_q, miss_addr_d;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             lookup_hit, lookup_miss, fill_en;
  logic             unused_off;

  assign req_idx  = imemaddr[IDX_W+BYTE_OFF-1:BYTE_OFF];
  assign req_tag  = imemaddr[WORD_W-1:IDX_W+BYTE_OFF];
  assign fill_idx = miss_addr_q[IDX_W-1:0];
  assign fill_tag = miss_addr_q[WORD_W-BYTE_OFF-1:IDX_W];
  assign unused_off = ^imemaddr[BYTE_OFF-1:0];

  // Lookup sees the valid bits from before any same-cycle flush.
  assign lookup_hit  = (state_q == IDLE) && imemREN && valid_q[req_idx]
                       && (tag_mem[req_idx] == req_tag);
  assign lookup_miss = (state_q == IDLE) && imemREN && !lookup_hit;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (lookup_miss) begin
          state_d     = FETCH;
          miss_addr_d = imemaddr[WORD_W-1:BYTE_OFF];
        end
      end
      FETCH: begin
        if (flush) begin
          state_d = IDLE;
        end else if (!iwait) begin
          fill_en           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) valid_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_en && !RST) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= iload;
    end
  end

  assign ihit     = lookup_hit;
  assign imemload = lookup_hit ? data_mem[req_idx] : '0;
  assign iREN     = (state_q == FETCH);
  assign iaddr    = iREN ? {miss_addr_q, {BYTE_OFF{1'b0}}} : '0;

  sat_counter #(.WIDTH(WORD_W)) u_hit_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .en    (lookup_hit),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(WORD_W)) u_miss_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .en    (lookup_miss),
    .count (miss_count)
  );
endmodule
